// File: rtl/rom_arb_pkg.sv
// Shared state encodings, owner identifiers and error-data constant for the
// ROM access arbiter.
package rom_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Wide enough for any practical DATA_W; users slice the low bits.
    localparam int unsigned             MAX_DATA_W = 64;
    localparam logic [MAX_DATA_W-1:0]   ERR_DATA   = '1;

endpackage

// File: rtl/rom_access_arbiter_if.sv
// Requester and ROM-side signals of the ROM access arbiter. The arbiter
// connects through the slave modport; requesters and the ROM use the master side.
interface rom_access_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 8
);

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic              cpu_valid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_ack;
    logic              dma_valid;
    logic [DATA_W-1:0] dma_rdata;

    logic              rd_err;
    logic              rom_oe;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  cpu_req, cpu_addr, dma_req, dma_addr, rom_data,
        output cpu_ack, cpu_valid, cpu_rdata,
        output dma_ack, dma_valid, dma_rdata,
        output rd_err, rom_oe, rom_addr
    );

    modport master (
        output cpu_req, cpu_addr, dma_req, dma_addr, rom_data,
        input  cpu_ack, cpu_valid, cpu_rdata,
        input  dma_ack, dma_valid, dma_rdata,
        input  rd_err, rom_oe, rom_addr
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-port grant logic: fixed priority to port 0, or round-robin keyed on the
// port that won the previous grant.
module rr_arbiter2
    import rom_arb_pkg::*;
#(
    parameter int unsigned CPU_PRIORITY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_owner
);

    logic r_last;
    logic w_dma_wins;

    always_comb begin
        // Port 1 wins when port 0 is silent, or on contention when port 0 won last.
        if (CPU_PRIORITY != 0) begin
            w_dma_wins = !i_req[0];
        end else begin
            w_dma_wins = !i_req[0] || (r_last == OWN_CPU);
        end
        o_gnt = 2'b00;
        if (i_en && (i_req != 2'b00)) begin
            if (i_req[1] && w_dma_wins) begin
                o_gnt[1] = 1'b1;
            end else begin
                o_gnt[0] = 1'b1;
            end
        end
    end

    assign o_owner = o_gnt[1] ? OWN_DMA : OWN_CPU;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= OWN_DMA;
        end else if (o_gnt != 2'b00) begin
            r_last <= o_owner;
        end
    end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares the program ROM between the CPU fetch port and the DMA/loader port,
// sequencing IDLE -> ACCESS (with wait states) -> RESP for each accepted read.
module rom_access_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ROM_SIZE     = 8192,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned CPU_PRIORITY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rom_access_arbiter_if.slave  bus
);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_owner;
    logic              r_oor;
    logic              r_rom_oe;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    logic              w_idle;
    logic [1:0]        w_gnt;
    logic              w_owner;
    logic              w_ack;
    logic              w_oor;
    logic              w_resp;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_cap_data;

    // Acks are suppressed while reset is held, even though they are combinational.
    assign w_idle = (r_state == ST_IDLE) && rst_n;

    rr_arbiter2 #(
        .CPU_PRIORITY (CPU_PRIORITY)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_idle),
        .i_req   ({bus.dma_req, bus.cpu_req}),
        .o_gnt   (w_gnt),
        .o_owner (w_owner)
    );

    assign w_ack      = |w_gnt;
    assign w_sel_addr = w_gnt[1] ? bus.dma_addr : bus.cpu_addr;
    assign w_oor      = 32'(w_sel_addr) >= ROM_SIZE;
    assign w_cap_data = r_oor ? ERR_DATA[DATA_W-1:0] : bus.rom_data;
    assign w_resp     = (r_state == ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_owner     <= OWN_CPU;
            r_oor       <= 1'b0;
            r_rom_oe    <= 1'b0;
            r_rom_addr  <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ack) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_owner <= w_owner;
                        r_oor   <= w_oor;
                        // Out-of-range reads never touch the ROM pins.
                        if (!w_oor) begin
                            r_rom_oe   <= 1'b1;
                            r_rom_addr <= w_sel_addr;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rom_oe <= 1'b0;
                        r_state  <= ST_RESP;
                        if (r_owner == OWN_DMA) begin
                            r_dma_rdata <= w_cap_data;
                        end else begin
                            r_cpu_rdata <= w_cap_data;
                        end
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_ack   = w_gnt[0];
    assign bus.dma_ack   = w_gnt[1];
    assign bus.cpu_valid = w_resp && (r_owner == OWN_CPU);
    assign bus.dma_valid = w_resp && (r_owner == OWN_DMA);
    assign bus.rd_err    = w_resp && r_oor;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dma_rdata = r_dma_rdata;
    assign bus.rom_oe    = r_rom_oe;
    assign bus.rom_addr  = r_rom_addr;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: two instances (round-robin/no wait states and
// fixed-priority/three wait states) checked every cycle against a timeline model.
module tb_rom_access_arbiter;

    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ROM_SIZE = 8192;
    localparam int unsigned WS_A     = 0;
    localparam int unsigned WS_B     = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [ROM_SIZE];

    // Drive side, index 0 = dut_a, 1 = dut_b.
    logic              d_creq  [2];
    logic [ADDR_W-1:0] d_caddr [2];
    logic              d_dreq  [2];
    logic [ADDR_W-1:0] d_daddr [2];

    logic              o_cack [2];
    logic              o_dack [2];
    logic              o_cval [2];
    logic              o_dval [2];
    logic              o_err  [2];
    logic              o_oe   [2];
    logic [ADDR_W-1:0] o_ra   [2];
    logic [DATA_W-1:0] o_crd  [2];
    logic [DATA_W-1:0] o_drd  [2];

    rom_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
    rom_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

    rom_access_arbiter #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .ROM_SIZE (ROM_SIZE),
        .WAIT_STATES (WS_A), .CPU_PRIORITY (0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    rom_access_arbiter #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .ROM_SIZE (ROM_SIZE),
        .WAIT_STATES (WS_B), .CPU_PRIORITY (1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    assign bus_a.cpu_req  = d_creq[0];
    assign bus_a.cpu_addr = d_caddr[0];
    assign bus_a.dma_req  = d_dreq[0];
    assign bus_a.dma_addr = d_daddr[0];
    assign bus_b.cpu_req  = d_creq[1];
    assign bus_b.cpu_addr = d_caddr[1];
    assign bus_b.dma_req  = d_dreq[1];
    assign bus_b.dma_addr = d_daddr[1];

    // ROM model: combinational read while enabled, a fixed junk value otherwise.
    assign bus_a.rom_data = bus_a.rom_oe ? mem[bus_a.rom_addr[12:0]] : 8'h3C;
    assign bus_b.rom_data = bus_b.rom_oe ? mem[bus_b.rom_addr[12:0]] : 8'h3C;

    assign o_cack[0] = bus_a.cpu_ack;    assign o_cack[1] = bus_b.cpu_ack;
    assign o_dack[0] = bus_a.dma_ack;    assign o_dack[1] = bus_b.dma_ack;
    assign o_cval[0] = bus_a.cpu_valid;  assign o_cval[1] = bus_b.cpu_valid;
    assign o_dval[0] = bus_a.dma_valid;  assign o_dval[1] = bus_b.dma_valid;
    assign o_err[0]  = bus_a.rd_err;     assign o_err[1]  = bus_b.rd_err;
    assign o_oe[0]   = bus_a.rom_oe;     assign o_oe[1]   = bus_b.rom_oe;
    assign o_ra[0]   = bus_a.rom_addr;   assign o_ra[1]   = bus_b.rom_addr;
    assign o_crd[0]  = bus_a.cpu_rdata;  assign o_crd[1]  = bus_b.cpu_rdata;
    assign o_drd[0]  = bus_a.dma_rdata;  assign o_drd[1]  = bus_b.dma_rdata;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, inst, act, exp,
                     $time);
        end
    endtask

    function automatic int ws_of(input int i);
        return (i == 0) ? int'(WS_A) : int'(WS_B);
    endfunction

    function automatic bit prio_of(input int i);
        return i != 0;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 15'h1FFF;
        if (r == 1) return 15'h2000;
        if (r == 2) return 15'($urandom_range(8192, 32767));
        return 15'($urandom_range(0, 8191));
    endfunction

    // ---------------- timeline reference model + per-cycle compare ----------------
    int                cyc = 0;
    int                idle_at [2];
    int                val_at  [2];
    int                oe_from [2];
    int                oe_to   [2];
    logic              m_own   [2];
    logic              m_oor   [2];
    logic              m_last  [2];
    logic [ADDR_W-1:0] m_gaddr [2];
    logic [ADDR_W-1:0] m_ra    [2];
    logic [DATA_W-1:0] m_rd    [2][2];
    logic              last_cack [2];
    logic              last_dack [2];

    always @(negedge clk) begin
        bit e_c;
        bit e_d;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                idle_at[i] = 0;
                val_at[i]  = -1;
                oe_from[i] = -1;
                oe_to[i]   = -2;
                m_oor[i]   = 1'b0;
                m_last[i]  = 1'b1;
                m_ra[i]    = '0;
                m_rd[i][0] = '0;
                m_rd[i][1] = '0;
                last_cack[i] = 1'b0;
                last_dack[i] = 1'b0;
                chk("rst_cpu_ack", i, 32'(o_cack[i]), 0);
                chk("rst_dma_ack", i, 32'(o_dack[i]), 0);
                chk("rst_valid", i, 32'(o_cval[i] | o_dval[i]), 0);
                chk("rst_err", i, 32'(o_err[i]), 0);
                chk("rst_oe", i, 32'(o_oe[i]), 0);
                chk("rst_addr", i, 32'(o_ra[i]), 0);
                chk("rst_rdata", i, 32'({o_crd[i], o_drd[i]}), 0);
            end else begin
                e_c = 1'b0;
                e_d = 1'b0;
                if (cyc >= idle_at[i]) begin
                    if (d_creq[i] && d_dreq[i]) begin
                        if (prio_of(i) || m_last[i]) e_c = 1'b1;
                        else                         e_d = 1'b1;
                    end else begin
                        e_c = d_creq[i];
                        e_d = d_dreq[i];
                    end
                end
                if (cyc == oe_from[i] && !m_oor[i]) m_ra[i] = m_gaddr[i];
                if (cyc == val_at[i]) begin
                    m_rd[i][m_own[i]] = m_oor[i] ? 8'hFF : mem[m_gaddr[i][12:0]];
                end
                chk("cpu_ack", i, 32'(o_cack[i]), 32'(e_c));
                chk("dma_ack", i, 32'(o_dack[i]), 32'(e_d));
                chk("cpu_valid", i, 32'(o_cval[i]), 32'(cyc == val_at[i] && !m_own[i]));
                chk("dma_valid", i, 32'(o_dval[i]), 32'(cyc == val_at[i] && m_own[i]));
                chk("rd_err", i, 32'(o_err[i]), 32'(cyc == val_at[i] && m_oor[i]));
                chk("rom_oe", i, 32'(o_oe[i]),
                    32'(!m_oor[i] && cyc >= oe_from[i] && cyc <= oe_to[i]));
                chk("rom_addr", i, 32'(o_ra[i]), 32'(m_ra[i]));
                chk("cpu_rdata", i, 32'(o_crd[i]), 32'(m_rd[i][0]));
                chk("dma_rdata", i, 32'(o_drd[i]), 32'(m_rd[i][1]));
                if (e_c || e_d) begin
                    m_own[i]   = e_d;
                    m_gaddr[i] = e_d ? d_daddr[i] : d_caddr[i];
                    m_oor[i]   = 32'(m_gaddr[i]) >= ROM_SIZE;
                    idle_at[i] = cyc + 3 + ws_of(i);
                    val_at[i]  = cyc + 2 + ws_of(i);
                    oe_from[i] = cyc + 1;
                    oe_to[i]   = cyc + 1 + ws_of(i);
                    m_last[i]  = e_d;
                end
                last_cack[i] = o_cack[i];
                last_dack[i] = o_dack[i];
            end
        end
        cyc++;
    end

    // One request on port (dma) of instance i; returns at T+1 with req dropped.
    task automatic issue(input int i, input bit dma, input logic [ADDR_W-1:0] a);
        @(posedge clk); #1;
        if (dma) begin d_dreq[i] = 1'b1; d_daddr[i] = a; end
        else     begin d_creq[i] = 1'b1; d_caddr[i] = a; end
        #1;
        chk(dma ? "issue_dma_ack" : "issue_cpu_ack", i,
            32'(dma ? o_dack[i] : o_cack[i]), 1);
        @(posedge clk); #1;
        if (dma) d_dreq[i] = 1'b0;
        else     d_creq[i] = 1'b0;
    endtask

    initial begin
        int        oe_n;
        int        vk;
        int        nval;
        bit        cseen;
        int        n_ack [2];
        int        t0    [2];
        int        t1    [2];
        logic [3:0] ord  [2];
        int        dack_b;

        for (int k = 0; k < int'(ROM_SIZE); k++) mem[k] = 8'($urandom);
        mem[0]        = 8'hA9;
        mem[13'h1FFD] = 8'h80;
        for (int i = 0; i < 2; i++) begin
            d_creq[i] = 1'b0; d_dreq[i] = 1'b0; d_caddr[i] = '0; d_daddr[i] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic CPU read, no wait states: valid two cycles after ack.
        issue(0, 0, 15'h0000);
        chk("t1_oe", 0, 32'(o_oe[0]), 1);
        chk("t1_rom_addr", 0, 32'(o_ra[0]), 0);
        @(posedge clk); #1;
        chk("t1_valid", 0, 32'(o_cval[0]), 1);
        chk("t1_rdata", 0, 32'(o_crd[0]), 32'h A9);
        chk("t1_err", 0, 32'(o_err[0]), 0);

        // DMA read with three wait states.
        issue(1, 1, 15'h1FFD);
        oe_n  = o_oe[1] ? 1 : 0;
        vk    = -1;
        cseen = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            @(posedge clk); #1;
            if (o_oe[1]) oe_n++;
            if (o_dval[1]) vk = k;
            if (o_cval[1]) cseen = 1'b1;
        end
        chk("t2_oe_cycles", 1, oe_n, 4);
        chk("t2_valid_at", 1, vk, 5);
        chk("t2_rdata", 1, 32'(o_drd[1]), 32'h80);
        chk("t2_cpu_valid", 1, 32'(cseen), 0);

        // Continuous contention from reset: alternation vs starvation.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        dack_b = 0;
        for (int i = 0; i < 2; i++) begin
            d_creq[i] = 1'b1; d_dreq[i] = 1'b1;
            d_caddr[i] = 15'($urandom_range(0, 8191));
            d_daddr[i] = 15'($urandom_range(0, 8191));
            n_ack[i] = 0; t0[i] = 0; t1[i] = 0; ord[i] = 4'hF;
        end
        for (int c = 0; c < 40; c++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                if (o_cack[i] || o_dack[i]) begin
                    if (n_ack[i] == 0) t0[i] = c;
                    if (n_ack[i] == 1) t1[i] = c;
                    if (n_ack[i] < 4) ord[i][n_ack[i]] = o_dack[i];
                    n_ack[i]++;
                end
            end
            if (o_dack[1]) dack_b++;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (last_cack[i]) d_caddr[i] = 15'($urandom_range(0, 8191));
                if (last_dack[i]) d_daddr[i] = 15'($urandom_range(0, 8191));
            end
        end
        chk("t4_order_rr", 0, 32'(ord[0]), 32'b1010);
        chk("t4_order_prio", 1, 32'(ord[1]), 32'b0000);
        chk("t4_dma_starved", 1, dack_b, 0);
        for (int i = 0; i < 2; i++) begin
            chk("t4_enough_acks", i, 32'(n_ack[i] >= 4), 1);
            chk("t4_back_to_back_gap", i, t1[i] - t0[i], 3 + ws_of(i));
            d_creq[i] = 1'b0; d_dreq[i] = 1'b0;
        end
        repeat (8) @(posedge clk);

        // Last in-range byte, then first out-of-range address.
        issue(0, 0, 15'h1FFF);
        chk("t5_edge_oe", 0, 32'(o_oe[0]), 1);
        chk("t5_edge_addr", 0, 32'(o_ra[0]), 32'h1FFF);
        @(posedge clk); #1;
        chk("t5_edge_rdata", 0, 32'(o_crd[0]), 32'(mem[13'h1FFF]));
        chk("t5_edge_err", 0, 32'(o_err[0]), 0);
        issue(0, 0, 15'h2000);
        chk("t5_oor_oe", 0, 32'(o_oe[0]), 0);
        chk("t5_oor_addr_held", 0, 32'(o_ra[0]), 32'h1FFF);
        @(posedge clk); #1;
        chk("t5_oor_valid", 0, 32'(o_cval[0]), 1);
        chk("t5_oor_err", 0, 32'(o_err[0]), 1);
        chk("t5_oor_rdata", 0, 32'(o_crd[0]), 32'hFF);

        // Reset in the middle of a wait-stated access.
        issue(1, 0, 15'h0005);
        chk("t6_oe_before", 1, 32'(o_oe[1]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_oe_async", 1, 32'(o_oe[1]), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        nval = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (o_cval[1] || o_dval[1]) nval++;
        end
        chk("t6_no_valid", 1, nval, 0);
        issue(1, 0, 15'h0010);
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk); #1;
        end
        chk("t6_after_valid", 1, 32'(o_cval[1]), 1);
        chk("t6_after_rdata", 1, 32'(o_crd[1]), 32'(mem[16]));
        @(posedge clk); #1;

        // Randomised traffic obeying the hold-until-ack protocol.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!d_creq[i] || last_cack[i]) begin
                    d_creq[i]  = ($urandom_range(0, 2) != 0);
                    d_caddr[i] = rand_addr();
                end
                if (!d_dreq[i] || last_dack[i]) begin
                    d_dreq[i]  = ($urandom_range(0, 2) != 0);
                    d_daddr[i] = rand_addr();
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            d_creq[i] = 1'b0; d_dreq[i] = 1'b0;
        end
        repeat (10) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
